// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: native word width and word type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/shift_left_2.sv
// Word-to-byte offset scaler: y = a << SHIFT, with the shifted-out bits and a lost-bits flag.
// Latency: y/lost/ovf are combinational (0 cycles); y_q/ovf_q/out_valid are 1 cycle.
// Backpressure: none; every in_valid beat is captured, no stall path exists.
import mips_pkg::*;

module shift_left_2 #(
  parameter int WIDTH = WORD_W,
  parameter int SHIFT = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [WIDTH-1:0]                     a,
  input  logic                                 in_valid,
  output logic [WIDTH-1:0]                     y,
  output logic [((SHIFT > 0) ? SHIFT : 1)-1:0] lost,
  output logic                                 ovf,
  output logic [WIDTH-1:0]                     y_q,
  output logic                                 ovf_q,
  output logic                                 out_valid
);

  // A zero-width lost bus cannot be declared, so SHIFT==0 keeps one bit tied low.
  localparam int LOST_W = (SHIFT > 0) ? SHIFT : 1;

  logic [WIDTH-1:0]  w_y;
  logic [LOST_W-1:0] w_lost;
  logic              w_ovf;

  logic [WIDTH-1:0]  r_y_q;
  logic              r_ovf_q;
  logic              r_out_valid;

  // Pure wiring: bits of a (including X/Z) map straight onto y, no clock or reset involved.
  generate
    if (SHIFT > 0) begin : g_shift
      assign w_y    = {a[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
      assign w_lost = a[WIDTH-1 -: SHIFT];
      assign w_ovf  = |w_lost;
    end else begin : g_no_shift
      assign w_y    = a;
      assign w_lost = '0;
      assign w_ovf  = 1'b0;
    end
  endgenerate

  // Pipeline copy: reset clears, a valid beat loads, an idle cycle holds data and drops valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y_q       <= '0;
      r_ovf_q     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_y_q       <= w_y;
      r_ovf_q     <= w_ovf;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = w_y;
  assign lost      = w_lost;
  assign ovf       = w_ovf;
  assign y_q       = r_y_q;
  assign ovf_q     = r_ovf_q;
  assign out_valid = r_out_valid;

endmodule : shift_left_2

// File: tb/tb_shift_left_2.sv
// Bench for shift_left_2: known-answer table, hand-written register sequences, random run.
// Latency: drives inputs 1 time unit after posedge; combinational checks at negedge.
// Backpressure: n/a (DUT has none).
module tb_shift_left_2;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  word_t      a;
  logic       in_valid;
  word_t      y;
  logic [1:0] lost;
  logic       ovf;
  word_t      y_q;
  logic       ovf_q;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state of the registered outputs, advanced by the spec rules.
  word_t m_yq;
  logic  m_ovfq;
  logic  m_vld;

  always #5 clk = ~clk;

  shift_left_2 #(.WIDTH(32), .SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .y         (y),
    .lost      (lost),
    .ovf       (ovf),
    .y_q       (y_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  // Arithmetic view: multiply by four modulo 2^32; lost bits are the top quarter index.
  function automatic word_t ref_y(input word_t v);
    logic [63:0] p;
    p = 64'(v) * 64'd4;
    return p[31:0];
  endfunction

  function automatic logic [1:0] ref_lost(input word_t v);
    word_t q;
    q = v / 32'h4000_0000;
    return q[1:0];
  endfunction

  function automatic logic ref_ovf(input word_t v);
    return (v >= 32'h4000_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock: check registers after the edge, apply new inputs, check comb path at negedge,
  // then advance the reference to what the next edge must produce.
  task automatic cycle(input word_t na, input logic nv, input logic nr);
    @(posedge clk);
    #1;
    chk("y_q", y_q, m_yq);
    chk("ovf_q", 32'(ovf_q), 32'(m_ovfq));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    a        = na;
    in_valid = nv;
    rst      = nr;
    @(negedge clk);
    chk("y", y, ref_y(na));
    chk("lost", 32'(lost), 32'(ref_lost(na)));
    chk("ovf", 32'(ovf), 32'(ref_ovf(na)));
    if (!nr) begin
      m_yq   = '0;
      m_ovfq = 1'b0;
      m_vld  = 1'b0;
    end else if (nv) begin
      m_yq   = ref_y(na);
      m_ovfq = ref_ovf(na);
      m_vld  = 1'b1;
    end else begin
      m_vld  = 1'b0;
    end
  endtask

  typedef struct {
    word_t      a;
    word_t      y;
    logic [1:0] lost;
    logic       ovf;
  } vec_t;

  initial begin
    vec_t vecs[8];
    word_t ra;
    logic  rv;
    logic  rr;

    rst      = 1'b0;
    a        = '0;
    in_valid = 1'b0;
    m_yq     = '0;
    m_ovfq   = 1'b0;
    m_vld    = 1'b0;

    vecs[0] = '{32'h0000_0001, 32'h0000_0004, 2'b00, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 2'b11, 1'b1};
    vecs[2] = '{32'h3FFF_FFFF, 32'hFFFF_FFFC, 2'b00, 1'b0};
    vecs[3] = '{32'h4000_0000, 32'h0000_0000, 2'b01, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, 2'b10, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h48D1_59E0, 2'b00, 1'b0};
    vecs[6] = '{32'hC000_0001, 32'h0000_0004, 2'b11, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 2'b00, 1'b0};

    // Reset held from time zero: registered outputs must read zero.
    cycle(32'h0000_0001, 1'b0, 1'b0);
    chk("reset y_q", y_q, 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);

    // Known-answer table on the combinational path, registered path streaming behind it.
    foreach (vecs[i]) begin
      cycle(vecs[i].a, 1'b1, 1'b1);
      chk("tbl y", y, vecs[i].y);
      chk("tbl lost", 32'(lost), 32'(vecs[i].lost));
      chk("tbl ovf", 32'(ovf), 32'(vecs[i].ovf));
    end

    // Capture one word, then two idle cycles: data holds, valid drops.
    cycle(32'h1234_5678, 1'b1, 1'b1);
    cycle(32'h0000_0010, 1'b0, 1'b1);
    chk("cap y_q", y_q, 32'h48D1_59E0);
    chk("cap out_valid", 32'(out_valid), 32'h1);
    cycle(32'h0000_0020, 1'b0, 1'b1);
    chk("hold y", y, 32'h0000_0080);
    chk("hold y_q", y_q, 32'h48D1_59E0);
    chk("hold out_valid", 32'(out_valid), 32'h0);

    // Capture an overflowing word, then reset mid-stream with in_valid still high.
    cycle(32'hFFFF_FFFF, 1'b1, 1'b1);
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("ovf cap ovf_q", 32'(ovf_q), 32'h1);
    chk("rst comb y", y, 32'hFFFF_FFFC);
    cycle(32'h0000_0003, 1'b1, 1'b1);
    chk("rst y_q", y_q, 32'h0);
    chk("rst ovf_q", 32'(ovf_q), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);

    // Random run against the arithmetic reference.
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 15) != 0);
      cycle(ra, rv, rr);
    end
    cycle(32'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_left_2
